// File: rtl/bus_copy_if.sv
// bus_copy_if -- signal bundle for the bus_copy word-copy engine.
//
// Groups the control handshake (start/abort/src/dst/len/busy/done/count)
// and the initiator-side bus (read/write/address/dout/din) into one bundle.
//   modport master : view used by bus_copy (drives control status and bus requests)
//   modport slave  : view used by the controller / bus responder
// Optional macro BUS_COPY_FILL_EN adds the fill and fill_data inputs.
interface bus_copy_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] din;
`ifdef BUS_COPY_FILL_EN
  logic              fill;
  logic [DATA_W-1:0] fill_data;

  modport master (
    input  start, abort, src, dst, len, din, fill, fill_data,
    output busy, done, count, read, write, address, dout
  );
  modport slave (
    output start, abort, src, dst, len, din, fill, fill_data,
    input  busy, done, count, read, write, address, dout
  );
`else
  modport master (
    input  start, abort, src, dst, len, din,
    output busy, done, count, read, write, address, dout
  );
  modport slave (
    output start, abort, src, dst, len, din,
    input  busy, done, count, read, write, address, dout
  );
`endif
endinterface

// File: rtl/bus_copy.sv
// bus_copy -- bus-initiator word copy engine.
//
// Copies len words from src to dst, one bus request per cycle, alternating
// READ and WRITE (2 cycles per word, 2N+1 busy cycles including FIN).
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : bus_copy_if.master -- start/abort/src/dst/len in, busy/done/count
//          out, read/write/address/dout out, din in
// Optional macro BUS_COPY_FILL_EN: adds fill/fill_data; a fill copy skips the
// READ phase and writes fill_data to len consecutive destinations, 1 cycle
// per word.
module bus_copy #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int STEP   = 4
) (
  input logic       clk,
  input logic       rst,
  bus_copy_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  state_t            state_q,   state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [LEN_W-1:0]  count_q,   count_d;
  // address/dout are registered so they stay stable for the whole request
  // cycle and keep their last value while idle.
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] dout_q,    dout_d;
  logic              last_word;
`ifdef BUS_COPY_FILL_EN
  logic              fill_q,    fill_d;
`endif

  // count_q < len_q always holds in WRITE, so the increment cannot overflow.
  assign last_word = !((count_q + LEN_W'(1)) < len_q);

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    len_d     = len_q;
    count_d   = count_q;
    address_d = address_q;
    dout_d    = dout_q;
`ifdef BUS_COPY_FILL_EN
    fill_d    = fill_q;
`endif

    case (state_q)
      IDLE: begin
        // abort is deliberately ignored here: start+abort still starts.
        if (bus.start) begin
          src_ptr_d = bus.src;
          dst_ptr_d = bus.dst;
          len_d     = bus.len;
          count_d   = '0;
`ifdef BUS_COPY_FILL_EN
          fill_d    = bus.fill;
`endif
          if (bus.len == '0) begin
            state_d = FIN;
`ifdef BUS_COPY_FILL_EN
          end else if (bus.fill) begin
            state_d   = WRITE;
            address_d = bus.dst;
            dout_d    = bus.fill_data;
`endif
          end else begin
            state_d   = READ;
            address_d = bus.src;
          end
        end
      end

      READ: begin
        src_ptr_d = src_ptr_q + STEP_A;
        if (bus.abort) begin
          // The read completes on the bus but its data is discarded, so dout
          // keeps showing the last word actually written.
          state_d = FIN;
        end else begin
          dout_d    = bus.din;
          state_d   = WRITE;
          address_d = dst_ptr_q;
        end
      end

      WRITE: begin
        dst_ptr_d = dst_ptr_q + STEP_A;
        count_d   = count_q + LEN_W'(1);
        if (bus.abort || last_word) begin
          state_d = FIN;
`ifdef BUS_COPY_FILL_EN
        end else if (fill_q) begin
          state_d   = WRITE;
          address_d = dst_ptr_q + STEP_A;
`endif
        end else begin
          state_d   = READ;
          address_d = src_ptr_q;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      len_q     <= '0;
      count_q   <= '0;
      address_q <= '0;
      dout_q    <= '0;
`ifdef BUS_COPY_FILL_EN
      fill_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      len_q     <= len_d;
      count_q   <= count_d;
      address_q <= address_d;
      dout_q    <= dout_d;
`ifdef BUS_COPY_FILL_EN
      fill_q    <= fill_d;
`endif
    end
  end

  // Request strobes decode straight from the state register so reset clears
  // them immediately without waiting for a clock edge.
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == FIN);
  assign bus.read    = (state_q == READ);
  assign bus.write   = (state_q == WRITE);
  assign bus.address = address_q;
  assign bus.dout    = dout_q;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_bus_copy.sv
module tb_bus_copy;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  typedef struct {
    int cyc;
    int cnt;
    int bcyc;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  xact_t       exp_q[$];
  logic [31:0] resp_q[$];
  done_t       done_q[$];

  bus_copy_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) bus ();

  bus_copy #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor / scoreboard / responder: samples on the falling edge.
  always @(negedge clk) begin
    xact_t x;
    done_t d;
    if (bus.busy) busy_run++;
    if (bus.read && bus.write) begin
      checks++;
      errors++;
      $display("FAIL rw_exclusive: read and write both high (cycle %0d)", cyc);
    end
    if (bus.read || bus.write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xact: wr=%0d addr=0x%0h, none required", bus.write, bus.address);
      end else begin
        x = exp_q.pop_front();
        check("xact_is_write", {63'd0, bus.write}, {63'd0, x.wr});
        check("xact_addr", {32'd0, bus.address}, {32'd0, x.addr});
        if (x.wr) check("write_data", {32'd0, bus.dout}, {32'd0, x.data});
      end
      if (bus.read) bus.din = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hBAD0BAD0;
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done high at cycle %0d, none required", cyc);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(d.cyc));
        check("done_count", {48'd0, bus.count}, 64'(d.cnt));
        check("busy_cycles", 64'(busy_run), 64'(d.bcyc));
      end
    end
    if (!bus.busy) busy_run = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    xact_t x;
    x.wr = wr; x.addr = addr; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic push_done(input int c, input int n, input int b);
    done_t d;
    d.cyc = c; d.cnt = n; d.bcyc = b;
    done_q.push_back(d);
  endtask

  // Drives start for one cycle; returns the cycle in which start was high.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] dd, input logic [15:0] n,
                            input bit fl, input logic [31:0] fdata, output int k);
    bus.src   = s;
    bus.dst   = dd;
    bus.len   = n;
`ifdef BUS_COPY_FILL_EN
    bus.fill      = fl;
    bus.fill_data = fdata;
`endif
    bus.start = 1'b1;
    k = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src   = '0;
    bus.dst   = '0;
    bus.len   = '0;
`ifdef BUS_COPY_FILL_EN
    bus.fill      = 1'b0;
    bus.fill_data = '0;
`endif
    #3;
    check("rst_read",    {63'd0, bus.read},  64'd0);
    check("rst_write",   {63'd0, bus.write}, 64'd0);
    check("rst_busy",    {63'd0, bus.busy},  64'd0);
    check("rst_done",    {63'd0, bus.done},  64'd0);
    check("rst_count",   {48'd0, bus.count}, 64'd0);
    check("rst_address", {32'd0, bus.address}, 64'd0);
    check("rst_dout",    {32'd0, bus.dout},  64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic 3-word copy; a stray start mid-copy must be ignored.
    push_x(0, 32'h100, 0); push_x(1, 32'h200, 32'hA);
    push_x(0, 32'h104, 0); push_x(1, 32'h204, 32'hB);
    push_x(0, 32'h108, 0); push_x(1, 32'h208, 32'hC);
    resp_q.push_back(32'hA); resp_q.push_back(32'hB); resp_q.push_back(32'hC);
    push_done(cyc + 7, 3, 7);
    start_copy(32'h100, 32'h200, 16'd3, 0, 0, k);
    tick(); tick();
    bus.src = 32'hDEAD0000; bus.len = 16'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();

    // len = 0: straight to FIN.
    push_done(cyc + 1, 0, 1);
    start_copy(32'h1000, 32'h2000, 16'd0, 0, 0, k);
    repeat (4) tick();

    // Address wrap, with abort asserted together with start.
    push_x(0, 32'hFFFFFFFC, 0); push_x(1, 32'h80000000, 32'h11);
    push_x(0, 32'h00000000, 0); push_x(1, 32'h80000004, 32'h22);
    resp_q.push_back(32'h11); resp_q.push_back(32'h22);
    push_done(cyc + 5, 2, 5);
    bus.abort = 1'b1;
    start_copy(32'hFFFFFFFC, 32'h80000000, 16'd2, 0, 0, k);
    bus.abort = 1'b0;
    repeat (7) tick();

    // len = 5, abort during the second WRITE.
    push_x(0, 32'h300, 0); push_x(1, 32'h400, 32'h1);
    push_x(0, 32'h304, 0); push_x(1, 32'h404, 32'h2);
    resp_q.push_back(32'h1); resp_q.push_back(32'h2);
    push_done(cyc + 5, 2, 5);
    start_copy(32'h300, 32'h400, 16'd5, 0, 0, k);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (6) tick();

    // Asynchronous reset in the middle of a READ cycle.
    start_copy(32'h500, 32'h600, 16'd3, 0, 0, k);
    #1 rst = 1'b1;
    #1;
    check("arst_read",    {63'd0, bus.read},  64'd0);
    check("arst_busy",    {63'd0, bus.busy},  64'd0);
    check("arst_done",    {63'd0, bus.done},  64'd0);
    check("arst_count",   {48'd0, bus.count}, 64'd0);
    check("arst_address", {32'd0, bus.address}, 64'd0);
    check("arst_dout",    {32'd0, bus.dout},  64'd0);
    #1 rst = 1'b0;
    repeat (4) tick();

    // Normal single-word copy after the reset.
    push_x(0, 32'h700, 0); push_x(1, 32'h800, 32'h77);
    resp_q.push_back(32'h77);
    push_done(cyc + 3, 1, 3);
    start_copy(32'h700, 32'h800, 16'd1, 0, 0, k);
    repeat (5) tick();

    // abort while idle: nothing must happen.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (3) tick();
    check("idle_abort_busy", {63'd0, bus.busy}, 64'd0);

`ifdef BUS_COPY_FILL_EN
    // Fill mode: two back-to-back writes, no reads.
    push_x(1, 32'h80000000, 32'h5); push_x(1, 32'h80000004, 32'h5);
    push_done(cyc + 3, 2, 3);
    start_copy(32'h0, 32'h80000000, 16'd2, 1, 32'h5, k);
    repeat (5) tick();
`endif

    check("leftover_xacts", 64'(exp_q.size()), 64'd0);
    check("leftover_dones", 64'(done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_copy.md
BUS_COPY -- requirements
Module: bus_copy

Interface
REQ-001 Parameter ADDR_W, default 32, bus address width.
REQ-002 Parameter DATA_W, default 32, bus data width.
REQ-003 Parameter LEN_W, default 16, word-count width.
REQ-004 Parameter STEP, default 4, address increment per word (byte addressing).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request a copy; sampled only in IDLE.
REQ-008 abort  input  1  terminate an active copy.
REQ-009 src  input  ADDR_W  first source address, latched on accepted start.
REQ-010 dst  input  ADDR_W  first destination address, latched on accepted start.
REQ-011 len  input  LEN_W  word count, latched on accepted start.
REQ-012 busy  output  1  high while not IDLE.
REQ-013 done  output  1  one-cycle pulse at completion or abort.
REQ-014 count  output  LEN_W  words written so far in the current/last copy.
REQ-015 read  output  1  bus read request.
REQ-016 write  output  1  bus write request.
REQ-017 address  output  ADDR_W  bus read/write address.
REQ-018 dout  output  DATA_W  bus write data.
REQ-019 din  input  DATA_W  bus read data.

Function
REQ-020 The block SHALL act as the bus initiator: one request per cycle, responder samples on the falling edge, and read data on din is valid at the rising edge ending the read cycle.
REQ-021 read and write SHALL never be high in the same cycle; address/dout SHALL be stable while read or write is high.
REQ-022 States SHALL be IDLE, READ, WRITE, FIN.
REQ-023 IDLE: start=1 latches src/dst/len, clears count; next state READ if len!=0, else FIN.
REQ-024 READ: read=1, address=src pointer; at cycle end din captured into a data register, src pointer += STEP; next state WRITE.
REQ-025 WRITE: write=1, address=dst pointer, dout=captured data; at cycle end dst pointer += STEP, count += 1; next READ if count+1<len, else FIN.
REQ-026 FIN: done=1 for exactly one cycle, read=write=0; next IDLE.
REQ-027 Throughput SHALL be 2 cycles per word; total busy time for len=N>0 SHALL be 2N+1 cycles.
REQ-028 Pointers SHALL wrap modulo 2^ADDR_W without error.
REQ-029 abort=1 in READ or WRITE SHALL force FIN at the next edge; the current cycle's request still completes; a READ aborted SHALL not be followed by its WRITE; count reflects only completed writes.
REQ-030 abort in IDLE or FIN SHALL have no effect; start outside IDLE SHALL be ignored; start and abort together in IDLE SHALL start the copy.
REQ-031 read, write SHALL be 0 in IDLE; address and dout hold their last values.

Reset
REQ-032 rst=1 SHALL immediately force IDLE and read=0, write=0, busy=0, done=0, count=0, address=0, dout=0, independent of clk.
REQ-033 Reset mid-copy SHALL abandon the copy with no done pulse.

Configuration
REQ-034 Macro BUS_COPY_FILL_EN: when defined, an extra input fill (1 bit, latched on start) and fill_data (DATA_W) exist; fill=1 skips READ, writing fill_data to len consecutive destinations at 1 cycle per word (busy time N+1).
REQ-035 Without BUS_COPY_FILL_EN the fill ports SHALL not exist and behaviour SHALL be as REQ-023..REQ-031 only.

Verification
REQ-036 src=0x100, dst=0x200, len=3, responder returns 0xA,0xB,0xC -> writes 0xA@0x200, 0xB@0x204, 0xC@0x208; done pulse 7 cycles after start; count=3.
REQ-037 len=0 start -> no read/write; done high exactly cycle after start; busy high 1 cycle.
REQ-038 src=0xFFFFFFFC, dst=0x80000000, len=2 -> reads 0xFFFFFFFC then 0x00000000; writes 0x80000000, 0x80000004.
REQ-039 len=5, abort asserted during 2nd WRITE -> that write occurs, no further read, done next cycle, count=2.
REQ-040 rst pulsed asynchronously mid-READ -> read drops before next clk edge; busy=0; no done; next start runs normally.
REQ-041 With BUS_COPY_FILL_EN, fill=1, fill_data=0x5, dst=0x80000000, len=2 -> two back-to-back writes of 0x5, read never high, done 3 cycles after start.
